// File: rtl/dp_pkg.sv
// ============================================================================
// Module : dp_pkg
// Brief  : Shared sizes and sequencer state encoding for the dp datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dp_pkg;

   localparam int DP_DEPTH = 16;
   localparam int DP_AW    = $clog2(DP_DEPTH);
   localparam int DP_DW    = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_REWIND = 3'd2,
      S_COPY_W = 3'd3,
      S_COPY_I = 3'd4,
      S_DONE   = 3'd5
   } state_e;

endpackage

`default_nettype wire

// File: rtl/dp_seq_cnt.sv
// ============================================================================
// Module : dp_seq_cnt
// Brief  : Loadable down-counter with zero flag; saturates at zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dp_seq_cnt #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load wins over decrement so a phase can hand over its count in one edge.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/dp_seq_ctrl.sv
// ============================================================================
// Module : dp_seq_ctrl
// Brief  : Load / rewind / copy sequencer driving the dp dual-pointer strobes.
//          Optional macro DP_SEQ_CTRL_ERR_EN adds a sticky err output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dp_seq_ctrl
   import dp_pkg::*;
#(
   parameter  int DEPTH = DP_DEPTH,
   parameter  int DW    = DP_DW,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW:0]   count,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          WEA,
   output logic [DW-1:0] dataInA,
   output logic          incA,
   output logic          WEB,
   output logic          incB,
   output logic          busy,
`ifdef DP_SEQ_CTRL_ERR_EN
   output logic          err,
`endif
   output logic          done
);

   localparam logic [AW:0] DEPTH_N = DEPTH[AW:0];

   state_e        state_q, state_d;
   logic [AW:0]   n_q, n_d;
   logic          cnt_load;
   logic [AW:0]   cnt_val;
   logic          cnt_dec;
   logic [AW:0]   cnt;
   logic          cnt_zero;
   logic          cnt_last;
   logic          over;
   logic [AW:0]   n_start;
   logic          hs;

   logic          wea_q, wea_d;
   logic          inca_q, inca_d;
   logic          web_q, web_d;
   logic          incb_q, incb_d;
   logic          done_q, done_d;
   logic [DW-1:0] data_q, data_d;
`ifdef DP_SEQ_CTRL_ERR_EN
   logic          err_q, err_d;
`endif

   dp_seq_cnt #(
      .W (AW + 1)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .cnt_o      (cnt),
      .zero_o     (cnt_zero)
   );

   assign over     = (count > DEPTH_N);
   assign n_start  = over ? DEPTH_N : count;
   assign hs       = in_valid && (state_q == S_LOAD);
   // Zero is folded in so a corrupted count still terminates the phase.
   assign cnt_last = (cnt == {{AW{1'b0}}, 1'b1}) || cnt_zero;

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      cnt_load = 1'b0;
      cnt_val  = n_q;
      cnt_dec  = 1'b0;
      wea_d    = 1'b0;
      inca_d   = 1'b0;
      web_d    = 1'b0;
      incb_d   = 1'b0;
      done_d   = 1'b0;
      data_d   = data_q;
`ifdef DP_SEQ_CTRL_ERR_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d      = n_start;
               cnt_load = 1'b1;
               cnt_val  = n_start;
`ifdef DP_SEQ_CTRL_ERR_EN
               err_d    = over;
               state_d  = (over || (count == '0)) ? S_DONE : S_LOAD;
`else
               state_d  = (n_start == '0) ? S_DONE : S_LOAD;
`endif
            end
         end
         S_LOAD: begin
            if (hs) begin
               wea_d   = 1'b1;
               inca_d  = 1'b1;
               data_d  = in_data;
               cnt_dec = 1'b1;
               if (cnt_last) begin
                  cnt_load = 1'b1;
                  if (n_q < DEPTH_N) begin
                     cnt_val = DEPTH_N - n_q;
                     state_d = S_REWIND;
                  end else begin
                     cnt_val = n_q;
                     state_d = S_COPY_W;
                  end
               end
            end
         end
         S_REWIND: begin
            inca_d  = 1'b1;
            cnt_dec = 1'b1;
            if (cnt_last) begin
               cnt_load = 1'b1;
               cnt_val  = n_q;
               state_d  = S_COPY_W;
            end
         end
         S_COPY_W: begin
            web_d   = 1'b1;
            state_d = S_COPY_I;
         end
         S_COPY_I: begin
            inca_d  = 1'b1;
            incb_d  = 1'b1;
            cnt_dec = 1'b1;
            state_d = cnt_last ? S_DONE : S_COPY_W;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes are registered from the decision made in the current state,
   // so they appear one cycle after the state that issues them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         wea_q   <= 1'b0;
         inca_q  <= 1'b0;
         web_q   <= 1'b0;
         incb_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
`ifdef DP_SEQ_CTRL_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wea_q   <= wea_d;
         inca_q  <= inca_d;
         web_q   <= web_d;
         incb_q  <= incb_d;
         done_q  <= done_d;
         data_q  <= data_d;
`ifdef DP_SEQ_CTRL_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   assign in_ready = (state_q == S_LOAD);
   assign busy     = (state_q != S_IDLE);
   assign WEA      = wea_q;
   assign incA     = inca_q;
   assign WEB      = web_q;
   assign incB     = incb_q;
   assign done     = done_q;
   assign dataInA  = data_q;
`ifdef DP_SEQ_CTRL_ERR_EN
   assign err      = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dp_seq_ctrl.sv
// ============================================================================
// Module : tb_dp_seq_ctrl
// Brief  : Directed table-driven bench for dp_seq_ctrl (DEPTH=16, DW=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dp_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] count;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       WEA;
   logic [7:0] dataInA;
   logic       incA;
   logic       WEB;
   logic       incB;
   logic       busy;
   logic       done;
`ifdef DP_SEQ_CTRL_ERR_EN
   logic       err;
`endif

   dp_seq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .count    (count),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .WEA      (WEA),
      .dataInA  (dataInA),
      .incA     (incA),
      .WEB      (WEB),
      .incB     (incB),
      .busy     (busy),
`ifdef DP_SEQ_CTRL_ERR_EN
      .err      (err),
`endif
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mode: 0 continuous valid, 1 valid toggling 1,0,1..., 2 continuous plus
   // a stray start (count=2) during LOAD
   typedef struct {
      logic [4:0] count;
      int         mode;
      int         wea;
      int         rew;
      int         web;
      int         pair;
      int         done_t;
      int         first_web;
      bit         err;
   } tv_t;

   tv_t tv [8];
   int  n_checks = 0;
   int  n_err    = 0;
   int  cur_row  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL row%0d %s: got %0d expected %0d", cur_row, name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_WEA"},     int'(WEA),     0);
      check({tag, "_incA"},    int'(incA),    0);
      check({tag, "_WEB"},     int'(WEB),     0);
      check({tag, "_incB"},    int'(incB),    0);
      check({tag, "_done"},    int'(done),    0);
      check({tag, "_dataInA"}, int'(dataInA), 0);
      check({tag, "_busy"},    int'(busy),    0);
      check({tag, "_inready"}, int'(in_ready), 0);
   endtask

   task automatic run_job(input tv_t v);
      int  t, nwea, nrew, nweb, npair, tdone, tfirst, ndata, nord, novl, phase, sent;
      bit  want_pair;
      t = 0; nwea = 0; nrew = 0; nweb = 0; npair = 0; tdone = -1; tfirst = 0;
      ndata = 0; nord = 0; novl = 0; phase = 0; sent = 0; want_pair = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      count    = v.count;
      in_valid = 1'b0;
      in_data  = 8'hFF;
      while (tdone < 0 && t < 200) begin
         @(negedge clk);
         t++;
         start = 1'b0;
         if (v.mode == 2 && t == 3) begin
            start = 1'b1;
            count = 5'd2;
         end
         if (t == 1) check("busy_t1", int'(busy), 1);
         if (WEA) begin
            nwea++;
            if (!incA || WEB || incB) novl++;
            if (dataInA != 8'(nwea - 1)) ndata++;
            if (phase != 0) nord++;
         end else if (WEB) begin
            nweb++;
            if (incA || incB) novl++;
            if (tfirst == 0) tfirst = t;
            if (want_pair) nord++;
            want_pair = 1'b1;
            phase = 2;
         end else if (incA && incB) begin
            npair++;
            if (!want_pair) nord++;
            want_pair = 1'b0;
            phase = 2;
         end else if (incB) begin
            novl++;
         end else if (incA) begin
            nrew++;
            if (phase == 2) nord++;
            phase = 1;
         end
         if (done) begin
            tdone = t;
            check("busy_at_done", int'(busy), 0);
`ifdef DP_SEQ_CTRL_ERR_EN
            check("err", int'(err), int'(v.err));
`endif
         end
         in_valid = (v.mode == 1) ? (t % 2 == 1) : 1'b1;
         in_data  = in_valid ? 8'(sent) : 8'hFF;
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      check("wea_pulses",   nwea,   v.wea);
      check("rewind_incA",  nrew,   v.rew);
      check("web_pulses",   nweb,   v.web);
      check("copy_pairs",   npair,  v.pair);
      check("done_cycle",   tdone,  v.done_t);
      check("first_web",    tfirst, v.first_web);
      check("data_errors",  ndata,  0);
      check("order_errors", nord,   0);
      check("overlap",      novl,   0);
      @(negedge clk);
      check("done_single",  int'(done), 0);
      check("busy_after",   int'(busy), 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0;

      tv[0] = '{5'd9,  0,  9,  7,  9,  9, 36, 18, 1'b0};
      tv[1] = '{5'd4,  1,  4, 12,  4,  4, 29, 21, 1'b0};
      tv[2] = '{5'd16, 0, 16,  0, 16, 16, 50, 18, 1'b0};
      tv[3] = '{5'd0,  0,  0,  0,  0,  0,  2,  0, 1'b0};
      tv[4] = '{5'd9,  2,  9,  7,  9,  9, 36, 18, 1'b0};
`ifdef DP_SEQ_CTRL_ERR_EN
      tv[5] = '{5'd20, 0,  0,  0,  0,  0,  2,  0, 1'b1};
`else
      tv[5] = '{5'd20, 0, 16,  0, 16, 16, 50, 18, 1'b0};
`endif
      tv[6] = '{5'd1,  0,  1, 15,  1,  1, 20, 18, 1'b0};
      tv[7] = '{5'd2,  1,  2, 14,  2,  2, 23, 19, 1'b0};

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
`ifdef DP_SEQ_CTRL_ERR_EN
      check("reset_err", int'(err), 0);
`endif
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         cur_row = i;
         run_job(tv[i]);
      end

      // Asynchronous reset landing in COPY_I of the third copy pair.
      cur_row = 8;
      @(negedge clk);
      start = 1'b1; count = 5'd9; in_valid = 1'b0;
      for (int t = 1; t <= 22; t++) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = 1'b1;
         in_data  = 8'(t);
      end
      check("pre_reset_WEB", int'(WEB), 1);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check_idle_outputs("midjob_rst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cur_row = 9;
      run_job('{5'd2, 0, 2, 14, 2, 2, 22, 18, 1'b0});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
